// File: rtl/operand_entry.sv
// Keypad operand-entry stage: builds two 0-255 decimal operands digit by digit.
// Optional macro OPERAND_BACKSPACE_EN enables the 0xB backspace key.
module operand_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  num,
  input  logic        load_num,
  output logic [7:0]  num_A,
  output logic [7:0]  num_B,
  output logic [15:0] num_o,
  output logic        signal_num
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic        load_q;
  logic [3:0]  d2_q, d1_q, d0_q, d2_d, d1_d, d0_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  num_a_q, num_a_d, num_b_q, num_b_d;
  logic [15:0] num_o_q, num_o_d;
  logic        signal_q, signal_d;

  logic        key_ev_s;
  logic        is_digit_s;
  logic        digit_ok_s;
  logic [9:0]  cand_s;
  logic [9:0]  buf_val_s;

  // Three BCD digits to binary using shifts and adds only (x*100 = 64x+32x+4x).
  function automatic logic [9:0] bcd_to_bin(input logic [3:0] h, input logic [3:0] t,
                                            input logic [3:0] o);
    logic [9:0] hh, tt, oo;
    hh = {6'd0, h};
    tt = {6'd0, t};
    oo = {6'd0, o};
    return (hh << 6) + (hh << 5) + (hh << 2) + (tt << 3) + (tt << 1) + oo;
  endfunction

  assign key_ev_s   = load_num & ~load_q;
  assign is_digit_s = (num <= 4'd9);
  assign cand_s     = bcd_to_bin(d1_q, d0_q, num);
  assign buf_val_s  = bcd_to_bin(d2_q, d1_q, d0_q);
  // With cnt below the limit d2 is zero, so the candidate only needs d1, d0 and the key.
  assign digit_ok_s = (cnt_q < MAX_CNT) && (cand_s <= 10'd255);

  // Next-state, entry buffer and operand commit logic.
  always_comb begin
    state_d = state_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    cnt_d   = cnt_q;
    num_a_d = num_a_q;
    num_b_d = num_b_q;
    if (key_ev_s) begin
      if (state_q == DONE) begin
        case (num)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            state_d = ENTER_A;
            d2_d    = 4'd0;
            d1_d    = 4'd0;
            d0_d    = num;
            cnt_d   = (num != 4'd0) ? 2'd1 : 2'd0;
          end
`ifdef OPERAND_BACKSPACE_EN
          4'hA, 4'hB, 4'hC: begin
`else
          4'hA, 4'hC: begin
`endif
            state_d = ENTER_A;
            d2_d    = 4'd0;
            d1_d    = 4'd0;
            d0_d    = 4'd0;
            cnt_d   = 2'd0;
          end
          default: state_d = state_q;
        endcase
      end else begin
        case (num)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            if (is_digit_s && digit_ok_s && !(cnt_q == 2'd0 && num == 4'd0)) begin
              d2_d  = d1_q;
              d1_d  = d0_q;
              d0_d  = num;
              cnt_d = cnt_q + 2'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end
          4'hA: begin
            if (state_q == ENTER_A) begin
              num_a_d = buf_val_s[7:0];
              state_d = ENTER_B;
            end else begin
              num_b_d = buf_val_s[7:0];
              state_d = DONE;
            end
            d2_d  = 4'd0;
            d1_d  = 4'd0;
            d0_d  = 4'd0;
            cnt_d = 2'd0;
          end
`ifdef OPERAND_BACKSPACE_EN
          4'hB: begin
            d2_d  = 4'd0;
            d1_d  = d2_q;
            d0_d  = d1_q;
            cnt_d = (cnt_q != 2'd0) ? (cnt_q - 2'd1) : 2'd0;
          end
`endif
          4'hC: begin
            d2_d    = 4'd0;
            d1_d    = 4'd0;
            d0_d    = 4'd0;
            cnt_d   = 2'd0;
            state_d = ENTER_A;
          end
          default: state_d = state_q;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output words derived from the next state so they are registered alongside it.
  always_comb begin
    num_o_d  = 16'h0000;
    signal_d = 1'b0;
    case (state_d)
      ENTER_A: num_o_d = {4'hA, d2_d, d1_d, d0_d};
      ENTER_B: num_o_d = {4'hB, d2_d, d1_d, d0_d};
      DONE:    signal_d = 1'b1;
      default: num_o_d = 16'h0000;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ENTER_A;
      load_q   <= 1'b0;
      d2_q     <= 4'd0;
      d1_q     <= 4'd0;
      d0_q     <= 4'd0;
      cnt_q    <= 2'd0;
      num_a_q  <= 8'd0;
      num_b_q  <= 8'd0;
      num_o_q  <= 16'hA000;
      signal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= load_num;
      d2_q     <= d2_d;
      d1_q     <= d1_d;
      d0_q     <= d0_d;
      cnt_q    <= cnt_d;
      num_a_q  <= num_a_d;
      num_b_q  <= num_b_d;
      num_o_q  <= num_o_d;
      signal_q <= signal_d;
    end
  end

  assign num_A      = num_a_q;
  assign num_B      = num_b_q;
  assign num_o      = num_o_q;
  assign signal_num = signal_q;

endmodule
